apb_req_arb: RTL and testbench
==============================

Name: apb_req_arb

Overview:
- Two-port APB master that lets two local requesters (e.g. crypto core and SPI config sequencer) share one APB bus segment.
- Each requester issues single read/write commands over a req/done handshake.
- The block arbitrates round-robin, drives the APB SETUP/ACCESS phases and decodes the two psel lines from the address.
- It returns read data and error status to the winning requester.

Parameters:
- ADDR_W, 20, APB address width.
- DATA_W, 16, APB data width.
- STRB_W, 2, byte strobe width (DATA_W/8).
- SEL_BIT, 19, address bit selecting psel[0] (bit=0) or psel[1] (bit=1).
- TIMEOUT_CYCLES, 16, ACCESS-phase cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  command request, held high until done seen.
- wr0 / wr1  in  1  1=write, 0=read.
- addr0 / addr1  in  ADDR_W  command address.
- wdata0 / wdata1  in  DATA_W  write data.
- strb0 / strb1  in  STRB_W  write strobes.
- done0 / done1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  DATA_W  read data, valid while done high.
- err0 / err1  out  1  error status, valid while done high.
- psel  out  2  APB slave selects, one-hot or zero.
- penable  out  1  APB enable.
- paddr  out  ADDR_W  APB address.
- pwrite  out  1  APB write.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  STRB_W  APB strobes.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset values: all outputs 0; state=IDLE; last_grant=1, so req0 wins the first tie.
- Reset is asynchronous. Asserting it mid-transfer drops psel/penable immediately and produces no done pulse.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Requests are sampled only when no done pulse is high in the same cycle, so a requester is never re-granted on its own done cycle.
  - Arbitration: if exactly one req is high, grant it. If both are high, grant the port != last_grant. Update last_grant.
  - Latch wr/addr/wdata/strb of the granted port; next state SETUP.
- SETUP (1 cycle):
  - psel[addr[SEL_BIT]]=1, penable=0; paddr/pwrite driven from latch.
  - pwdata/pstrb driven from latch on writes; forced to 0 on reads.
  - Next state ACCESS.
- ACCESS:
  - penable=1; psel and all control held stable.
  - pready=0: stay in ACCESS (wait state).
  - pready=1: capture prdata (reads only; writes return 0) and pslverr; drop psel/penable; go to IDLE.
  - In the following cycle, pulse done of the granted port with rdata/err.
- Latency: req high at edge N gives SETUP in cycle N+1, ACCESS in N+2, and done in N+3 with zero wait states. Each wait state adds 1 cycle.
- Minimum spacing: 4 cycles per transfer (IDLE, SETUP, ACCESS, done/IDLE).
- Outputs to the non-granted port stay 0.
- psel is never active in IDLE. paddr/pwdata hold their last values when idle.
- Dropping req mid-transfer is illegal; the transfer still completes and done still pulses.

Optional Feature:
- Macro APB_ARB_TIMEOUT_EN.
- Defined:
  - An ACCESS-phase counter counts cycles with pready=0.
  - On reaching TIMEOUT_CYCLES, the transfer aborts: psel/penable drop, the granted port gets a done pulse with err=1 and rdata=0, and the extra output port "timeout" (1 bit, reset 0) pulses for 1 cycle with done.
  - The counter clears on entry to SETUP.
- Undefined: no counter and no timeout port; ACCESS waits for pready indefinitely.

Test Plan:
- Write, single port: req0, wr0=1, addr0=20'h00010, wdata0=16'h1234, strb0=2'b11, pready=1 -> psel=2'b01 in SETUP, penable high 1 cycle, done0 pulses at N+3, err0=0.
- Read with waits, other slave: req1, wr1=0, addr1=20'h80004, pready low 3 ACCESS cycles, prdata=16'hABCD -> psel=2'b10, pstrb=0, done1 at N+6, rdata1=16'hABCD.
- Contention: req0 and req1 high together from reset -> port 0 served first, then port 1. Keeping both high -> grants alternate 0,1,0,1 with no port served twice in a row.
- Slave error: pslverr=1 with pready=1 on a port-0 write -> done0 with err0=1; next transfer err0=0.
- Reset mid-ACCESS: assert reset while penable=1 -> psel/penable 0 within the same cycle, no done. After release, a pending req is re-served from IDLE.
- With APB_ARB_TIMEOUT_EN and pready tied 0: done0 with err0=1 and rdata0=0, timeout pulses exactly 16 cycles into ACCESS.

Source files
------------

// File: rtl/apb_req_arb.sv
// apb_req_arb: round-robin arbiter letting two local requesters share one APB segment.
// Optional macro APB_ARB_TIMEOUT_EN adds an ACCESS-phase abort with a one-cycle timeout pulse.
module apb_req_arb #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int STRB_W  = 2,
    parameter int SEL_BIT = 19
`ifdef APB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [STRB_W-1:0] strb0,
    input  logic [STRB_W-1:0] strb1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [1:0]        psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
`ifdef APB_ARB_TIMEOUT_EN
    output logic              timeout,
`endif
    input  logic              pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state;
    logic              last_grant;
    logic              gnt;
    logic              grant_any;
    logic              grant_sel;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_strb;
    logic [DATA_W-1:0] cap_rdata;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] tcnt;
`endif

    // Arbitration is suppressed while a done pulse is out, so a requester that is
    // still holding req on its own done cycle cannot be granted a second time.
    always_comb begin
        grant_any = 1'b0;
        grant_sel = 1'b0;
        if (!done0 && !done1) begin
            if (req0 && req1) begin
                grant_any = 1'b1;
                grant_sel = ~last_grant;
            end else if (req0) begin
                grant_any = 1'b1;
            end else if (req1) begin
                grant_any = 1'b1;
                grant_sel = 1'b1;
            end
        end
        sel_wr    = grant_sel ? wr1    : wr0;
        sel_addr  = grant_sel ? addr1  : addr0;
        sel_wdata = grant_sel ? wdata1 : wdata0;
        sel_strb  = grant_sel ? strb1  : strb0;
    end

    assign cap_rdata = pwrite ? '0 : prdata;

    // The APB output registers double as the command latch, so paddr/pwdata
    // naturally hold their last values while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            psel       <= '0;
            penable    <= 1'b0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            pstrb      <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            err0       <= 1'b0;
            err1       <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            tcnt       <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
            done0  <= 1'b0;
            done1  <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
            err0   <= 1'b0;
            err1   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        gnt        <= grant_sel;
                        last_grant <= grant_sel;
                        psel       <= sel_addr[SEL_BIT] ? 2'b10 : 2'b01;
                        penable    <= 1'b0;
                        paddr      <= sel_addr;
                        pwrite     <= sel_wr;
                        pwdata     <= sel_wr ? sel_wdata : '0;
                        pstrb      <= sel_wr ? sel_strb  : '0;
`ifdef APB_ARB_TIMEOUT_EN
                        tcnt       <= '0;
`endif
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel    <= '0;
                        penable <= 1'b0;
                        state   <= IDLE;
                        if (gnt) begin
                            done1  <= 1'b1;
                            rdata1 <= cap_rdata;
                            err1   <= pslverr;
                        end else begin
                            done0  <= 1'b1;
                            rdata0 <= cap_rdata;
                            err0   <= pslverr;
                        end
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: report an error with zero read data to the owner.
                        psel    <= '0;
                        penable <= 1'b0;
                        state   <= IDLE;
                        timeout <= 1'b1;
                        if (gnt) begin
                            done1 <= 1'b1;
                            err1  <= 1'b1;
                        end else begin
                            done0 <= 1'b1;
                            err0  <= 1'b1;
                        end
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arb.sv
// Directed bench for apb_req_arb: scoreboard of expected completions checked on every done pulse.
module tb_apb_req_arb;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int STRB_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, req1, wr0, wr1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [STRB_W-1:0] strb0, strb1;
    logic              done0, done1, err0, err1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [1:0]        psel;
    logic              penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready, pslverr;
`ifdef APB_ARB_TIMEOUT_EN
    logic              timeout;
`endif

    apb_req_arb dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .strb0(strb0), .strb1(strb1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
`ifdef APB_ARB_TIMEOUT_EN
        .timeout(timeout),
`endif
        .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              port;
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              to;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic port, input logic [DATA_W-1:0] rd, input logic err, input logic to);
        exp_t e;
        e.port = port; e.rdata = rd; e.err = err; e.to = to;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(done0 || done1) && n < bound);
        chk("done_wait", 32'(done0 | done1), 32'd1);
    endtask

    // Completion monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && (done0 || done1)) begin
            chk("done_onehot", 32'(done0 & done1), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'({done1, done0}), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_port", 32'(done1), 32'(e.port));
                chk("done_rdata", 32'(e.port ? rdata1 : rdata0), 32'(e.rdata));
                chk("done_err", 32'(e.port ? err1 : err0), 32'(e.err));
                chk("other_rdata", 32'(e.port ? rdata0 : rdata1), 32'd0);
                chk("other_err", 32'(e.port ? err0 : err1), 32'd0);
`ifdef APB_ARB_TIMEOUT_EN
                chk("timeout_pulse", 32'(timeout), 32'(e.to));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; strb0 = '0; strb1 = '0;
        prdata = '0; pready = 1'b1; pslverr = 1'b0;
        repeat (2) step();

        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_done", 32'({done1, done0}), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwdata", 32'(pwdata), 32'd0);
        chk("rst_pwrite_pstrb", 32'({pwrite, pstrb}), 32'd0);
        reset = 1'b0;
        step();

        // Write on port 0, zero wait states
        req0 = 1'b1; wr0 = 1'b1; addr0 = 20'h00010; wdata0 = 16'h1234; strb0 = 2'b11;
        prdata = 16'hDEAD;
        push(1'b0, 16'h0000, 1'b0, 1'b0);
        step();
        chk("w_setup_psel", 32'(psel), 32'd1);
        chk("w_setup_penable", 32'(penable), 32'd0);
        chk("w_setup_paddr", 32'(paddr), 32'h00010);
        chk("w_setup_pwrite", 32'(pwrite), 32'd1);
        chk("w_setup_pwdata", 32'(pwdata), 32'h1234);
        chk("w_setup_pstrb", 32'(pstrb), 32'd3);
        step();
        chk("w_access_penable", 32'(penable), 32'd1);
        chk("w_access_psel", 32'(psel), 32'd1);
        chk("w_access_nodone", 32'(done0), 32'd0);
        step();
        chk("w_done0_lat3", 32'(done0), 32'd1);
        chk("w_done_psel", 32'(psel), 32'd0);
        chk("w_done_penable", 32'(penable), 32'd0);
        req0 = 1'b0;
        step();
        chk("w_done_one_cycle", 32'(done0), 32'd0);
        chk("idle_paddr_hold", 32'(paddr), 32'h00010);

        // Read on port 1, slave 1, three wait states
        req1 = 1'b1; wr1 = 1'b0; addr1 = 20'h80004; wdata1 = 16'h5555; strb1 = 2'b11;
        pready = 1'b0; prdata = 16'hABCD;
        push(1'b1, 16'hABCD, 1'b0, 1'b0);
        step();
        chk("r_setup_psel", 32'(psel), 32'd2);
        chk("r_setup_pstrb", 32'(pstrb), 32'd0);
        chk("r_setup_pwdata", 32'(pwdata), 32'd0);
        chk("r_setup_pwrite", 32'(pwrite), 32'd0);
        chk("r_setup_paddr", 32'(paddr), 32'h80004);
        step();
        chk("r_access_penable", 32'(penable), 32'd1);
        step();
        step();
        chk("r_wait_psel", 32'(psel), 32'd2);
        step();
        chk("r_wait_nodone", 32'(done1), 32'd0);
        pready = 1'b1;
        step();
        chk("r_done1_lat6", 32'(done1), 32'd1);
        req1 = 1'b0;
        step();

        // Contention from reset: port 0 first, then strict alternation
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = 20'h00020; addr1 = 20'h80020; prdata = 16'h0F0F; pready = 1'b1;
        step();
        reset = 1'b0;
        push(1'b0, 16'h0F0F, 1'b0, 1'b0);
        push(1'b1, 16'h0F0F, 1'b0, 1'b0);
        push(1'b0, 16'h0F0F, 1'b0, 1'b0);
        push(1'b1, 16'h0F0F, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done0 || done1) begin
                seen++;
                if (seen == 4) begin
                    req0 = 1'b0; req1 = 1'b0;
                    break;
                end
            end
        end
        chk("contention_count", 32'(seen), 32'd4);
        step();

        // Slave error on a port-0 write, then a clean transfer
        req0 = 1'b1; wr0 = 1'b1; addr0 = 20'h00100; wdata0 = 16'hBEEF; strb0 = 2'b01;
        pslverr = 1'b1; prdata = 16'h4321;
        push(1'b0, 16'h0000, 1'b1, 1'b0);
        wait_done(10);
        chk("slverr_err0", 32'(err0), 32'd1);
        req0 = 1'b0; pslverr = 1'b0;
        step();
        req0 = 1'b1; wdata0 = 16'h0001;
        push(1'b0, 16'h0000, 1'b0, 1'b0);
        wait_done(10);
        chk("after_slverr_err0", 32'(err0), 32'd0);
        req0 = 1'b0;
        step();

        // Asynchronous reset during ACCESS, then re-service of the pending request
        req1 = 1'b1; wr1 = 1'b0; addr1 = 20'h80040; pready = 1'b0; prdata = 16'h7777;
        step();
        step();
        chk("pre_rst_penable", 32'(penable), 32'd1);
        chk("pre_rst_psel", 32'(psel), 32'd2);
        reset = 1'b1;
        #1;
        chk("rst_async_psel", 32'(psel), 32'd0);
        chk("rst_async_penable", 32'(penable), 32'd0);
        step();
        step();
        chk("rst_no_done", 32'({done1, done0}), 32'd0);
        reset = 1'b0; pready = 1'b1;
        push(1'b1, 16'h7777, 1'b0, 1'b0);
        wait_done(10);
        chk("rerun_done1", 32'(done1), 32'd1);
        req1 = 1'b0;
        step();

`ifdef APB_ARB_TIMEOUT_EN
        // Timeout with pready stuck low
        begin
            int n;
            req0 = 1'b1; wr0 = 1'b0; addr0 = 20'h00200; pready = 1'b0; prdata = 16'h1111;
            push(1'b0, 16'h0000, 1'b1, 1'b1);
            step();
            step();
            chk("to_access_penable", 32'(penable), 32'd1);
            n = 0;
            do begin
                step();
                n++;
            end while (!(done0 || done1) && n < 40);
            chk("to_cycles", 32'(n), 32'd16);
            chk("to_pulse", 32'(timeout), 32'd1);
            chk("to_err0", 32'(err0), 32'd1);
            chk("to_rdata0", 32'(rdata0), 32'd0);
            chk("to_psel", 32'(psel), 32'd0);
            req0 = 1'b0; pready = 1'b1;
            step();
            chk("to_pulse_clear", 32'(timeout), 32'd0);
        end
`endif

        repeat (3) step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
